multi_timer: RTL
================

# multi_timer

Parametrised multi-channel down-counting timer with per-channel periodic/one-shot modes, prescalers and interrupt-pending flags. Successor to the single fixed 50,000,000-cycle fabric-interrupt timer, with which it keeps the same `fabint` interrupt output. Software programs it through a simple synchronous register port. It sits beside the fabric interrupt controller and drives `fabint` plus a per-channel interrupt vector.

## Interface
- `CHANNELS`, default 4: number of independent timer channels, 1..16.
- `WIDTH`, default 32: counter, load and data-bus width, minimum 16.
- `AW`, default 4: address width. Must satisfy AW ≥ clog2(CHANNELS)+2.

- `pclk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high reset. Clears all state immediately.
- `wen` in 1: register write strobe, sampled on `pclk`.
- `addr` in AW: register address, {channel, reg[1:0]}. Used for both writes and reads.
- `wdata` in WIDTH: write data.
- `rdata` out WIDTH: combinational read data for `addr`.
- `irq` out CHANNELS: per-channel interrupt, pending & irqen.
- `fabint` out 1: OR of all `irq` bits.

## Operation
- Per-channel registers, selected by reg[1:0]:
  - 0 LOAD (RW, WIDTH bits): reload value.
  - 1 CTRL (RW):
    - bit0 enable.
    - bit1 mode: 0 = periodic, 1 = one-shot.
    - bit2 irqen.
    - bits[15:8] prescale P.
    - All other bits read 0.
  - 2 STATUS: bit0 pending, write-1-to-clear. Writing 0 has no effect.
  - 3 COUNT (RO): current count. Writes are ignored.
- Channel indices ≥ CHANNELS: writes are ignored and reads return 0.
- Per-channel state: count (WIDTH bits) and prescale counter pc (8 bits).
- Enabling a channel:
  - A CTRL write that takes enable from 0 to 1 sets count ← LOAD and pc ← 0.
  - A CTRL write with enable already 1 updates mode, irqen and P only. It does not restart the count.
  - A CTRL write with enable = 0 freezes count and pc. Their values remain readable.
- While enabled, every cycle:
  - If pc == P: pc ← 0 and a tick occurs.
  - Otherwise: pc ← pc+1.
  - If P is lowered below the current pc, pc wraps naturally through 255 to 0.
- On a tick:
  - If count ≠ 0: count ← count−1.
  - If count == 0 (expiry): pending ← 1, then by mode:
    - Periodic: count ← LOAD, same edge.
    - One-shot: enable ← 0 and count stays 0.
- The period is (LOAD+1)·(P+1) cycles. LOAD=0 with P=0 in periodic mode expires every cycle.
- A LOAD write while running takes effect at the next reload or enable only.
- Simultaneous events in the same cycle:
  - Expiry and a STATUS W1C: set wins, so pending stays 1.
  - Expiry and a CTRL write that clears enable: the write wins. No expiry, and pending is unchanged.
  - One-shot expiry and a CTRL write that sets enable: enable stays 1 and count ← LOAD. The write takes priority; pending is still set.
- A CTRL irqen change does not affect pending. It only masks `irq`.

## Timing
- Reset values:
  - All LOAD, CTRL, count, pc and pending are 0.
  - `irq` = 0, `fabint` = 0, `rdata` = 0.
- Reset asserted mid-count aborts immediately. No interrupt is generated.
- Register writes take effect on the `pclk` edge where `wen` = 1.
- `rdata` reflects the register state after that edge, within the same cycle, with no read latency.
- First expiry: with the enable write at edge E, pending rises at edge E + (LOAD+1)·(P+1).
- `irq` and `fabint` are combinational from pending/irqen registers. They assert in the cycle following the expiry edge and stay high (level) until cleared.
- A W1C at edge C drops `irq`/`fabint` after C, unless another channel is still pending.

## Test plan
- Reset and defaults:
  - Stimulus: assert `reset` asynchronously mid-cycle with channel 0 running, LOAD=10.
  - Required: all outputs 0 immediately; COUNT reads 0 and CTRL reads 0 after release.
- Periodic, no prescale:
  - Stimulus: ch0 LOAD=4, CTRL=0x5 (enable, periodic, irqen).
  - Required: pending at enable-edge+5; `fabint` high; COUNT reads 4 again on the same edge.
  - Required: after W1C, the next pending arrives 5 cycles after the previous one.
- Prescale and one-shot:
  - Stimulus: ch1 LOAD=2, CTRL=0x0307 (P=3, one-shot, irqen, enable).
  - Required: pending at enable-edge+12; CTRL bit0 then reads 0; COUNT holds 0; no further expiry over 100 cycles.
- Simultaneous events:
  - Stimulus A: W1C on ch0 in the exact expiry cycle. Required: pending remains 1.
  - Stimulus B: CTRL enable=0 written in the expiry cycle. Required: pending unchanged at 0.
- Multi-channel, masking and address bounds:
  - Stimulus: ch2 and ch3 both expire, ch3 irqen=0.
  - Required: `irq`=4'b0100, `fabint`=1; STATUS of ch3 reads 1.
  - Stimulus (CHANNELS=3): write to a channel-3 address. Required: no state change, and the read returns 0.
- Reprogramming while running:
  - Stimulus: ch0 LOAD=9 running; write LOAD=2 mid-count.
  - Required: the current period still totals 10 ticks; subsequent periods are 3 ticks.

Source files
------------

// File: rtl/multi_timer.sv
// -----------------------------------------------------------------------------
// multi_timer
//
// Multi-channel down-counting timer. Each channel has a reload value, an 8-bit
// prescaler and a periodic or one-shot mode. A channel raises a pending flag
// when it expires. Software programs the channels through a small synchronous
// register port. The flags drive a per-channel interrupt vector and the
// aggregated fabric interrupt `fabint`.
//
// Register map: addr = {channel, reg[1:0]}
//   0 LOAD   RW  reload value (WIDTH bits)
//   1 CTRL   RW  bit0 enable, bit1 one-shot, bit2 irqen, bits[15:8] prescale
//   2 STATUS W1C bit0 pending
//   3 COUNT  RO  current count
//
// Ports
//   pclk    in             sole clock, rising edge
//   reset   in             asynchronous active-high reset
//   wen     in             register write strobe
//   addr    in  [AW-1:0]   register address, used for writes and reads
//   wdata   in  [WIDTH-1:0] write data
//   rdata   out [WIDTH-1:0] combinational read data for addr
//   irq     out [CHANNELS-1:0] pending & irqen, per channel
//   fabint  out            OR of all irq bits
// -----------------------------------------------------------------------------
module multi_timer #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 32,
  parameter int AW       = 4
) (
  input  logic                pclk,
  input  logic                reset,
  input  logic                wen,
  input  logic [AW-1:0]       addr,
  input  logic [WIDTH-1:0]    wdata,
  output logic [WIDTH-1:0]    rdata,
  output logic [CHANNELS-1:0] irq,
  output logic                fabint
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Channel index taken from the upper address bits. Indices that do not
  // match any channel select nothing, so writes there are dropped and the
  // read mux returns 0.
  logic [AW-1:0] chan_idx;
  logic [1:0]    reg_sel;

  assign chan_idx = addr >> 2;
  assign reg_sel  = addr[1:0];

  logic [CHANNELS-1:0][WIDTH-1:0] rd_vec;
  logic [CHANNELS-1:0]            pend_vec;
  logic [CHANNELS-1:0]            irqen_vec;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic             sel;
      logic             wr_load;
      logic             wr_ctrl;
      logic             wr_stat;

      logic [WIDTH-1:0] load_q,  load_d;
      logic             en_q,    en_d;
      logic             mode_q,  mode_d;
      logic             irqen_q, irqen_d;
      logic [7:0]       psc_q,   psc_d;
      logic [WIDTH-1:0] count_q, count_d;
      logic [7:0]       pc_q,    pc_d;
      logic             pend_q,  pend_d;

      logic             tick;
      logic             expire;
      logic [15:0]      ctrl_word;
      logic [WIDTH-1:0] rd_word;

      assign sel     = (chan_idx == AW'(gi));
      assign wr_load = wen && sel && (reg_sel == 2'd0);
      assign wr_ctrl = wen && sel && (reg_sel == 2'd1);
      assign wr_stat = wen && sel && (reg_sel == 2'd2);

      always_comb begin
        load_d  = load_q;
        en_d    = en_q;
        mode_d  = mode_q;
        irqen_d = irqen_q;
        psc_d   = psc_q;
        count_d = count_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        tick    = 1'b0;
        expire  = 1'b0;

        // A LOAD write only lands in the reload register; the running count
        // picks it up at the next reload or enable.
        if (wr_load) begin
          load_d = wdata;
        end

        if (wr_ctrl) begin
          mode_d  = wdata[1];
          irqen_d = wdata[2];
          psc_d   = wdata[15:8];
        end

        if (wr_ctrl && !wdata[0]) begin
          // Disabling freezes count and pc, and suppresses any expiry that
          // would have happened on this edge.
          en_d = 1'b0;
        end else if (wr_ctrl && !en_q) begin
          // Rising enable: restart from the reload value.
          en_d    = 1'b1;
          count_d = load_q;
          pc_d    = 8'd0;
        end else if (en_q) begin
          // Running. A CTRL write with enable=1 lands here too: it only
          // updates mode/irqen/P and the count keeps going.
          if (pc_q == psc_q) begin
            pc_d = 8'd0;
            tick = 1'b1;
          end else begin
            // If P was lowered below pc, this wraps through 255 to 0.
            pc_d = pc_q + 8'd1;
          end

          if (tick) begin
            if (count_q != '0) begin
              count_d = count_q - ONE;
            end else begin
              expire  = 1'b1;
              count_d = load_q;
              // One-shot stops at 0, unless a CTRL write re-asserts enable
              // on this same edge. In that case the channel keeps running
              // from the reload value.
              if (mode_q && !wr_ctrl) begin
                en_d    = 1'b0;
                count_d = '0;
              end
            end
          end
        end

        // Expiry overrides a simultaneous W1C so that no event is lost.
        if (wr_stat && wdata[0]) begin
          pend_d = 1'b0;
        end
        if (expire) begin
          pend_d = 1'b1;
        end
      end

      always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
          load_q  <= '0;
          en_q    <= 1'b0;
          mode_q  <= 1'b0;
          irqen_q <= 1'b0;
          psc_q   <= 8'd0;
          count_q <= '0;
          pc_q    <= 8'd0;
          pend_q  <= 1'b0;
        end else begin
          load_q  <= load_d;
          en_q    <= en_d;
          mode_q  <= mode_d;
          irqen_q <= irqen_d;
          psc_q   <= psc_d;
          count_q <= count_d;
          pc_q    <= pc_d;
          pend_q  <= pend_d;
        end
      end

      assign ctrl_word = {psc_q, 5'b0, irqen_q, mode_q, en_q};

      always_comb begin
        rd_word = '0;
        case (reg_sel)
          2'd0:    rd_word = load_q;
          2'd1:    rd_word = WIDTH'(ctrl_word);
          2'd2:    rd_word = WIDTH'(pend_q);
          default: rd_word = count_q;
        endcase
      end

      // Only the addressed channel contributes to the read OR-tree.
      assign rd_vec[gi]    = sel ? rd_word : '0;
      assign pend_vec[gi]  = pend_q;
      assign irqen_vec[gi] = irqen_q;
    end
  endgenerate

  always_comb begin
    rdata = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      rdata = rdata | rd_vec[i];
    end
  end

  assign irq    = pend_vec & irqen_vec;
  assign fabint = |irq;

endmodule
